// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start bit, 7/8 data bits LSB first, optional parity, one stop.
// Owns the shift register and bit-time counter; tx_out is driven straight from a flop.
module uart_tx_frame_ctrl #(
    parameter int unsigned BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [7:0]        data_in,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              tx_out,
    output logic              tx_rdy,
    output logic              tx_done
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [10:0]       sr_q, sr_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        len_q, len_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_done_q, tx_done_d;

    logic [7:0]        data_sel;
    logic              par;
    logic              baud_wrap;
    logic [3:0]        bit_cnt_inc;

    always_comb begin
        data_sel    = {data_in[7] & eight, data_in[6:0]};
        par         = ohel ^ (^data_sel);
        // >= so a live decrease of baud_k mid-bit cannot make the counter overrun
        baud_wrap   = (baud_cnt_q >= baud_k);
        bit_cnt_inc = bit_cnt_q + 4'd1;
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        baud_cnt_d = baud_cnt_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_out_d = 1'b1;
                if (load) begin
                    state_d    = StShift;
                    sr_d       = {1'b1,
                                  (eight & pen) ? par : 1'b1,
                                  eight ? data_in[7] : (pen ? par : 1'b1),
                                  data_in[6:0],
                                  1'b0};
                    len_d      = 4'd9 + {3'b000, eight} + {3'b000, pen};
                    bit_cnt_d  = 4'd0;
                    baud_cnt_d = '0;
                    // Start bit goes out the cycle after the load edge
                    tx_out_d   = 1'b0;
                end
            end
            StShift: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    sr_d       = {1'b1, sr_q[10:1]};
                    bit_cnt_d  = bit_cnt_inc;
                    if (bit_cnt_inc >= len_q) begin
                        state_d   = StIdle;
                        tx_done_d = 1'b1;
                        tx_out_d  = 1'b1;
                        sr_d      = '1;
                        bit_cnt_d = 4'd0;
                    end else begin
                        tx_out_d = sr_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            sr_q       <= '1;
            bit_cnt_q  <= 4'd0;
            len_q      <= 4'd0;
            baud_cnt_q <= '0;
            tx_out_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            baud_cnt_q <= baud_cnt_d;
            tx_out_q   <= tx_out_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_rdy  = (state_q == StIdle);
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: table of frames with hand-derived bit patterns,
// per-bit expectations queued at load time and popped while the line is sampled.
module tb_uart_tx_frame_ctrl;

    localparam int unsigned BAUD_W = 19;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load = 1'b0;
    logic [7:0]        data_in = 8'h00;
    logic              eight = 1'b0;
    logic              pen = 1'b0;
    logic              ohel = 1'b0;
    logic [BAUD_W-1:0] baud_k = '0;
    logic              tx_out;
    logic              tx_rdy;
    logic              tx_done;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        eight;
        logic        pen;
        logic        ohel;
        int unsigned k;
        int unsigned len;
        logic [10:0] frame;  // frame[i] = i-th bit on the line
    } vec_t;

    vec_t vecs[7];

    uart_tx_frame_ctrl #(.BAUD_W(BAUD_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .data_in (data_in),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .baud_k  (baud_k),
        .tx_out  (tx_out),
        .tx_rdy  (tx_rdy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Call just after a negedge; load is accepted on the next posedge. Returns at the
    // negedge of the tx_done cycle, so the caller may chain a back-to-back load.
    task automatic run_frame(input vec_t v, input bit cfg_flip, input bit spurious);
        bit e;
        data_in = v.data;
        eight   = v.eight;
        pen     = v.pen;
        ohel    = v.ohel;
        baud_k  = BAUD_W'(v.k);
        load    = 1'b1;
        for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.frame[i]);
        for (int b = 0; b < int'(v.len); b++) begin
            e = exp_q.pop_front();
            for (int c = 0; c <= int'(v.k); c++) begin
                @(negedge clk);
                load = 1'b0;
                if (cfg_flip && b == 0 && c == 0) begin
                    eight   = ~eight;
                    pen     = ~pen;
                    ohel    = ~ohel;
                    data_in = ~data_in;
                end
                check($sformatf("tx_out bit%0d", b), 32'(tx_out), 32'(e));
                check("tx_rdy busy", 32'(tx_rdy), 32'd0);
                check("tx_done busy", 32'(tx_done), 32'd0);
                if (spurious && b >= 2 && b <= 8 && c == 0) begin
                    load    = 1'b1;
                    data_in = ~v.data;
                end
            end
        end
        @(negedge clk);
        load = 1'b0;
        check("tx_done end", 32'(tx_done), 32'd1);
        check("tx_rdy end", 32'(tx_rdy), 32'd1);
        check("tx_out idle", 32'(tx_out), 32'd1);
    endtask

    task automatic check_done_fell();
        @(negedge clk);
        check("tx_done pulse width", 32'(tx_done), 32'd0);
        check("tx_out after done", 32'(tx_out), 32'd1);
    endtask

    initial begin
        //            data   8  p  o  k  N   frame
        vecs[0] = '{8'hA5, 1, 0, 0, 3, 10, 11'h34A};  // 8N1
        vecs[1] = '{8'hC1, 0, 1, 0, 1, 10, 11'h282};  // 7E1, bit 7 ignored
        vecs[2] = '{8'hFF, 1, 1, 1, 0, 11, 11'h7FE};  // 8O1
        vecs[3] = '{8'h35, 0, 0, 0, 0, 9,  11'h16A};  // 7N1
        vecs[4] = '{8'h00, 0, 1, 1, 2, 10, 11'h300};  // 7O1, parity 1
        vecs[5] = '{8'h80, 1, 1, 0, 1, 11, 11'h700};  // 8E1, parity 1
        vecs[6] = '{8'h00, 1, 0, 0, 0, 10, 11'h200};  // 8N1 all zeros

        #1 reset = 1'b0;
        #11;
        check("reset tx_out", 32'(tx_out), 32'd1);
        check("reset tx_rdy", 32'(tx_rdy), 32'd1);
        check("reset tx_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], 1'b0, 1'b0);
            check_done_fell();
        end

        // 7N1 with loads during bits 2-8 ignored, then a load in the tx_done cycle
        run_frame(vecs[3], 1'b0, 1'b1);
        run_frame(vecs[4], 1'b0, 1'b0);
        check_done_fell();

        // Config and data changes after load must not alter the frame
        run_frame(vecs[1], 1'b1, 1'b0);
        check_done_fell();
        run_frame(vecs[5], 1'b1, 1'b0);
        check_done_fell();

        // Asynchronous reset during data bit 3 of 0xA5 (bit 3 = 0 on the line)
        data_in = 8'hA5;
        eight   = 1'b1;
        pen     = 1'b0;
        ohel    = 1'b0;
        baud_k  = BAUD_W'(3);
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (16) @(negedge clk);
        check("pre-reset data bit3", 32'(tx_out), 32'd0);
        check("pre-reset tx_rdy", 32'(tx_rdy), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async reset tx_out", 32'(tx_out), 32'd1);
        check("async reset tx_rdy", 32'(tx_rdy), 32'd1);
        check("async reset tx_done", 32'(tx_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset idle", 32'(tx_out), 32'd1);
        run_frame(vecs[0], 1'b0, 1'b0);
        check_done_fell();

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Sequences one asynchronous serial transmit frame: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit.
- Frame length is selected from the {eight, pen} configuration. Bit timing comes from an internal bit-time counter; the block owns the transmit shift register.
- Sits between the CPU-side transmit data register and the TX pin in the UART. It is the transmit engine that the status/interrupt logic watches through tx_rdy and tx_done.

Parameters:
- BAUD_W, 19, width of the bit-time terminal count input baud_k.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle request to transmit data_in; honoured only while tx_rdy=1.
- data_in  input  8  byte to send; bit 7 is ignored when eight=0.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits.
- pen  input  1  parity enable.
- ohel  input  1  parity sense: 1 = odd, 0 = even.
- baud_k  input  BAUD_W  bit-time terminal count; each bit lasts baud_k+1 clocks.
- tx_out  output  1  serial line; idles high.
- tx_rdy  output  1  1 = idle and able to accept load.
- tx_done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (asynchronous, active-low), applied immediately even mid-frame:
  - tx_out=1, tx_rdy=1, tx_done=0.
  - state=IDLE; shift register all 1s; bit counter and baud counter 0.
- States: IDLE, SHIFT.
- IDLE → SHIFT on load=1 at a clock edge.
  - That edge latches data_in, eight, pen and ohel, and the frame length N = 9/10/10/11 for {eight,pen} = 00/01/10/11.
  - The same edge loads the 11-bit shift register:
    - sr[0] = 0 (start bit).
    - sr[7:1] = data_in[6:0].
    - sr[8] = eight ? data_in[7] : (pen ? par : 1).
    - sr[9] = (eight & pen) ? par : 1.
    - sr[10] = 1.
  - Parity: par = ohel XOR (XOR of the selected data bits). data_in[7] is masked out when eight=0.
  - tx_rdy falls on the same edge.
- SHIFT:
  - tx_out = sr[0], registered, so the start bit appears at the first clock edge after load.
  - The baud counter counts 0..baud_k. At baud_k it wraps to 0, sr shifts right with 1 fill, and the bit counter increments.
  - When the bit counter reaches N on a wrap: return to IDLE, tx_rdy=1, tx_done=1 for exactly one cycle, tx_out=1.
- Latency and timing:
  - First bit is driven for baud_k+1 clocks starting the cycle after the load edge.
  - A frame occupies N*(baud_k+1) clocks.
  - tx_done and tx_rdy rise together N*(baud_k+1) clocks after the load edge.
  - baud_k=0 gives one clock per bit.
- load while tx_rdy=0 is ignored: no queuing, and the current frame is not disturbed.
- load in the cycle tx_done is high is accepted, because tx_rdy is already 1 in that cycle. A back-to-back frame then starts with no idle bit.
- eight, pen, ohel and data_in changes during SHIFT have no effect; only the latched copies are used.
- baud_k is sampled live. Changing it mid-frame affects only the remaining bit times, and the counter compares with >= so it cannot overrun.
- tx_out is glitch-free, driven directly from a flop.

Test Plan:
- 8N1, eight=1 pen=0, baud_k=3, load data_in=0xA5:
  - tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks.
  - tx_done pulse and tx_rdy=1 exactly 40 clocks after the load edge.
- 7E1, eight=0 pen=1 ohel=0, baud_k=1, data_in=0xC1:
  - bit 7 ignored; data 1,0,0,0,0,0,1; parity 0.
  - Frame 0,1,0,0,0,0,0,1,0,1, 10 bits × 2 clocks; tx_done at 20.
- 8O1, eight=1 pen=1 ohel=1, baud_k=0, data_in=0xFF:
  - 11-bit frame 0, eight 1s, parity 1, stop 1.
  - tx_done 11 clocks after load.
- 7N1 with baud_k=0:
  - 9-bit frame.
  - A second load issued during bits 2-8 is ignored (tx_out unchanged).
  - A load in the tx_done cycle starts the next start bit on the following clock.
- Reset asserted mid-frame (during data bit 3):
  - tx_out=1 and tx_rdy=1 immediately, without waiting for a clock edge.
  - After release, a fresh load transmits a full correct frame.
- Config change mid-frame: toggle eight and pen after load → frame length and parity still follow the latched values.
